// File: rtl/alu_mdu_if.sv
// Execute-stage request/result bus for alu_mdu: request handshake, operands, flush and result handshake.
interface alu_mdu_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] y;
    logic            illegal;

    modport master (
        output flush, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, illegal
    );

    modport slave (
        input  flush, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, illegal
    );
endinterface

// File: rtl/alu_mdu.sv
// Valid/ready execute unit: single-cycle integer ops plus iterative (bit-serial) RV32M multiply/divide.
// Define ALU_MDU_DIV_EN to build the divider; without it ops 20-23 complete at once with illegal=1.
module alu_mdu #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input logic      clk,
    input logic      rst,
    alu_mdu_if.slave bus
);
    localparam int unsigned     SH_W      = $clog2(XLEN);
    localparam logic [4:0]      OP_MUL    = 5'd16;
    localparam logic [4:0]      OP_MULH   = 5'd17;
    localparam logic [4:0]      OP_MULHSU = 5'd18;
    localparam logic [4:0]      OP_MULHU  = 5'd19;
    localparam logic [4:0]      OP_DIV    = 5'd20;
    localparam logic [4:0]      OP_REMU   = 5'd23;
    localparam logic [XLEN-1:0] MIN_VAL   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [XLEN-1:0]  hi, lo, opnd, y_r;
    logic             illegal_r;
    logic [CNT_W-1:0] cnt;
    logic             hi_sel;   // MULH*: high product half; divide: remainder
    logic             neg;      // negate the final magnitude
`ifdef ALU_MDU_DIV_EN
    logic             is_mul;
    logic             l_mul;
    logic [XLEN:0]    d_t;
    logic [XLEN-1:0]  d_diff;
    logic             d_ge;
`endif

    logic [4:0]      op;
    logic            accept, is_mul_op, is_div_op;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    state_t          l_state;
    logic [XLEN-1:0] l_y;
    logic            l_ill, l_hi_sel, l_neg;
    logic [XLEN:0]   m_sum;
    logic [XLEN-1:0] hi_n, lo_n, res;
    logic [2*XLEN-1:0] prod;

    function automatic logic [XLEN-1:0] simple_res(input logic [4:0] o,
                                                   input logic [XLEN-1:0] x,
                                                   input logic [XLEN-1:0] z);
        logic [SH_W-1:0] sh;
        sh = z[SH_W-1:0];
        case (o)
            5'd0:    return x + z;
            5'd1:    return x - z;
            5'd2:    return x & z;
            5'd3:    return x | z;
            5'd4:    return x ^ z;
            5'd5:    return x << sh;
            5'd6:    return x >> sh;
            5'd7:    return XLEN'($signed(x) >>> sh);
            default: return z;
        endcase
    endfunction

    assign op        = bus.op;
    assign is_mul_op = (op >= OP_MUL) && (op <= OP_MULHU);
    assign is_div_op = (op >= OP_DIV) && (op <= OP_REMU);
    assign accept    = bus.in_valid && bus.in_ready && !bus.flush;

    // What an accepted request loads: final result for one-cycle ops, operand magnitudes otherwise
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (is_mul_op) begin
            a_neg = ((op == OP_MULH) || (op == OP_MULHSU)) && bus.a[XLEN-1];
            b_neg = (op == OP_MULH) && bus.b[XLEN-1];
        end
`ifdef ALU_MDU_DIV_EN
        else if (is_div_op) begin
            a_neg = !op[0] && bus.a[XLEN-1];
            b_neg = !op[0] && bus.b[XLEN-1];
        end
`endif
        abs_a    = a_neg ? -bus.a : bus.a;
        abs_b    = b_neg ? -bus.b : bus.b;
        l_state  = DONE;
        l_y      = simple_res(op, bus.a, bus.b);
        l_ill    = 1'b0;
        l_hi_sel = 1'b0;
        l_neg    = 1'b0;
`ifdef ALU_MDU_DIV_EN
        l_mul    = 1'b1;
`endif
        if (is_mul_op) begin
            l_state  = BUSY;
            l_hi_sel = (op != OP_MUL);
            l_neg    = a_neg ^ b_neg;
        end else if (is_div_op) begin
`ifdef ALU_MDU_DIV_EN
            l_hi_sel = op[1];
            l_mul    = 1'b0;
            if (bus.b == '0) begin
                l_y = op[1] ? bus.a : '1;
            end else if (!op[0] && (bus.a == MIN_VAL) && (bus.b == '1)) begin
                l_y = op[1] ? '0 : bus.a;
            end else begin
                l_state = BUSY;
                l_neg   = op[1] ? a_neg : (a_neg ^ b_neg);
            end
`else
            l_y   = '0;
            l_ill = 1'b1;
`endif
        end
    end

    // One iteration: shift-add multiply or restoring shift-subtract divide, plus sign fix-up
    always_comb begin
        m_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        hi_n  = m_sum[XLEN:1];
        lo_n  = {m_sum[0], lo[XLEN-1:1]};
`ifdef ALU_MDU_DIV_EN
        d_t    = {hi, lo[XLEN-1]};
        d_ge   = d_t >= {1'b0, opnd};
        d_diff = XLEN'(d_t - {1'b0, opnd});
        if (!is_mul) begin
            hi_n = d_ge ? d_diff : d_t[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], d_ge};
        end
`endif
        prod = {hi_n, lo_n};
        if (neg) prod = -prod;
        res = hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`ifdef ALU_MDU_DIV_EN
        if (!is_mul) begin
            res = hi_sel ? hi_n : lo_n;
            if (neg) res = -res;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            y_r       <= '0;
            illegal_r <= 1'b0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            hi_sel    <= 1'b0;
            neg       <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            is_mul    <= 1'b1;
`endif
        end else if (bus.flush) begin
            state <= IDLE;
        end else if (accept) begin
            state     <= l_state;
            illegal_r <= l_ill;
            hi        <= '0;
            lo        <= abs_a;
            opnd      <= abs_b;
            hi_sel    <= l_hi_sel;
            neg       <= l_neg;
            cnt       <= (l_state == BUSY) ? CNT_W'(XLEN) : '0;
`ifdef ALU_MDU_DIV_EN
            is_mul    <= l_mul;
`endif
            if (l_state == DONE) y_r <= l_y;
        end else if (state == BUSY) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                y_r   <= res;
                state <= DONE;
            end
        end else if ((state == DONE) && bus.out_ready) begin
            state <= IDLE;
        end
    end

    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign bus.y         = y_r;
    assign bus.illegal   = illegal_r;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu with an arithmetic reference model checked every cycle.
module tb_alu_mdu;
    localparam int unsigned XLEN = 32;
`ifdef ALU_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mdu_if #(.XLEN(XLEN)) bus ();
    alu_mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_wait = 0;

    typedef struct {
        logic [31:0] y;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic m_ov, m_ir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_div(input logic [4:0] op);
        return (op >= 5'd20) && (op <= 5'd23);
    endfunction

    // Reference result straight from the RV32 operation definitions using 64-bit arithmetic
    function automatic logic [31:0] model_y(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        logic [4:0] sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sh = b[4:0];
        if (!DIV_EN && is_div(op)) return 32'h0;
        case (op)
            5'd0:  r = ua + ub;
            5'd1:  r = ua - ub;
            5'd2:  r = ua & ub;
            5'd3:  r = ua | ub;
            5'd4:  r = ua ^ ub;
            5'd5:  r = ua << sh;
            5'd6:  r = ua >> sh;
            5'd7:  r = sa >>> sh;
            5'd16: r = sa * sb;
            5'd17: r = (sa * sb) >>> 32;
            5'd18: r = (sa * ub) >>> 32;
            5'd19: r = (ua * ub) >> 32;
            5'd20: r = (b == 0) ? -64'sd1 : ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? ua : sa / sb);
            5'd21: r = (b == 0) ? -64'sd1 : ua / ub;
            5'd22: r = (b == 0) ? ua : ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 64'sd0 : sa % sb);
            5'd23: r = (b == 0) ? ua : ua % ub;
            default: r = ub;
        endcase
        return r[31:0];
    endfunction

    function automatic logic model_ill(input logic [4:0] op);
        return !DIV_EN && is_div(op);
    endfunction

    function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 5'd16 && op <= 5'd19) return 33;
        if (DIV_EN && is_div(op) && b != 0 && !(!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 33;
        return 1;
    endfunction

    // Compare process: outputs checked against the model on every cycle out of reset
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
        end else begin
            m_ov = (q.size() > 0) && (cyc - q[0].acc >= q[0].lat);
            m_ir = (q.size() == 0) || (m_ov && bus.out_ready);
            chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
            chk("in_ready", 32'(bus.in_ready), 32'(m_ir));
            if (m_ov) begin
                chk("y", bus.y, q[0].y);
                chk("illegal", 32'(bus.illegal), 32'(q[0].ill));
            end
            if (bus.flush) begin
                q.delete();
            end else begin
                if (m_ov && bus.out_ready) void'(q.pop_front());
                if (bus.in_valid && m_ir) begin
                    e.y   = model_y(bus.op, bus.a, bus.b);
                    e.ill = model_ill(bus.op);
                    e.acc = cyc;
                    e.lat = model_lat(bus.op, bus.a, bus.b);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit);
        int waited;
        waited = 0;
        chk({"pin_", name}, model_y(op, a, b), lit);
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!(bus.in_ready && !bus.flush) && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept: waited %0d cycles, want under 200", name, waited);
        end
        last_wait = waited;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results pending, want 0", q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.op = 5'd0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;
        cycles(3);
        chk("rst_y", bus.y, 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_illegal", 32'(bus.illegal), 32'h0);
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Simple ops back to back
        send("add", 5'd0, 32'd5, 32'd7, 32'd12);
        send("sra", 5'd7, 32'h80000000, 32'd4, 32'hF8000000);
        chk("sra_no_bubble", 32'(last_wait), 32'h0);

        // Multiply
        send("mul", 5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        send("mulhu", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        send("mulh", 5'd17, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF);
        send("mulhsu", 5'd18, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);

        // Divide and special cases
        send("div", 5'd20, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32'hFFFFFFFD : 32'h0);
        send("rem", 5'd22, 32'hFFFFFFF9, 32'd2, DIV_EN ? 32'hFFFFFFFF : 32'h0);
        send("divu_by0", 5'd21, 32'd9, 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'h0);
        send("remu_by0", 5'd23, 32'd9, 32'd0, DIV_EN ? 32'd9 : 32'h0);
        send("div_ovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 32'h80000000 : 32'h0);
        send("rem_ovf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        drain();

        // Backpressure: result held for 10 cycles, then release together with a new request
        bus.out_ready = 1'b0;
        send("divu_bp", 5'd21, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'h0);
        cycles(43);
        bus.out_ready = 1'b1;
        send("add_bp", 5'd0, 32'd1, 32'd2, 32'd3);
        chk("accept_same_edge", 32'(last_wait), 32'h0);
        drain();

        // Flush mid-multiply, then a request offered under flush must be ignored
        send("mul_flush", 5'd16, 32'd6, 32'd7, 32'd42);
        cycles(11);
        bus.flush = 1'b1;
        bus.op = 5'd0;
        bus.a = 32'd1;
        bus.b = 32'd1;
        bus.in_valid = 1'b1;
        cycles(2);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid), 32'h0);
        cycles(40);

        // Asynchronous reset mid-multiply
        send("mul_rst", 5'd16, 32'd3, 32'd5, 32'd15);
        cycles(5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_y", bus.y, 32'h0);
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("async_rst_illegal", 32'(bus.illegal), 32'h0);
        cycles(2);
        rst = 1'b0;
        cycles(40);

        // Remaining ops and build-dependent divide behaviour
        send("sub", 5'd1, 32'd5, 32'd7, 32'hFFFFFFFE);
        send("and", 5'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        send("or", 5'd3, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0);
        send("xor", 5'd4, 32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0);
        send("sll", 5'd5, 32'h00000003, 32'd31, 32'h80000000);
        send("srl", 5'd6, 32'h80000000, 32'd36, 32'h08000000);
        send("pass", 5'd9, 32'd123, 32'hCAFEF00D, 32'hCAFEF00D);
        send("mul_small", 5'd16, 32'd6, 32'd7, 32'd42);
        chk("pin_mul_illegal", 32'(model_ill(5'd16)), 32'h0);
        send("div_small", 5'd20, 32'd10, 32'd2, DIV_EN ? 32'd5 : 32'h0);
        chk("pin_div_illegal", 32'(model_ill(5'd20)), DIV_EN ? 32'h0 : 32'h1);
        send("remu", 5'd23, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'h0);
        drain();
        cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, sequential successor to the single-cycle execute ALU: a valid/ready execute unit that adds RV32M multiply/divide to the existing integer ops. Simple ops complete in one cycle. Multiply and divide run iteratively, one bit per cycle. It sits in the EX stage; the pipeline stalls on `in_ready` low and consumes results on the `out_valid`/`out_ready` handshake.

## Interface
- `XLEN`, default 32: operand/result width; must be even and ≥ 8.
- `CNT_W`, default $clog2(XLEN)+1: iteration counter width.

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  abort any in-flight op, drop held result
- `in_valid`  in  1  request valid
- `in_ready`  out  1  unit can accept request this cycle
- `op`  in  5  operation code
- `a`  in  XLEN  operand rs1
- `b`  in  XLEN  operand rs2 / immediate
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer takes result
- `y`  out  XLEN  result
- `illegal`  out  1  qualifies `y`; op not supported by this build

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU.
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code returns `y = b` (pass-through).
- Shift amount is `b[$clog2(XLEN)-1:0]`; SRA is arithmetic.
- States:
  - IDLE: accepts on `in_valid && in_ready`.
  - Simple op, or divide special case: result registered on the accepting edge → DONE.
  - MUL/DIV op: operands registered, magnitudes taken for signed variants, counter = XLEN → BUSY.
  - BUSY: one shift-add (multiply) or restoring shift-subtract (divide) step per edge, counter decrements. The step with counter==1 applies sign correction, registers `y` → DONE.
  - DONE: `out_valid=1`, `y` and `illegal` held stable. On `out_ready`: → IDLE, or directly accept a new request the same edge.
- `in_ready = (state==IDLE) || (state==DONE && out_ready)`. Low in BUSY.
- Multiply keeps a 2·XLEN product. MUL returns the low half; the MULH* variants return the high half with the signedness given by the op.
- Divide special cases (one-cycle, no BUSY):
  - b==0: quotient all-ones, remainder = a.
  - Signed a==min, b==−1: quotient = min, remainder 0.
- Signed divide: quotient sign = sign(a)^sign(b); remainder sign follows a.
- `flush`: forces IDLE on the next edge from any state and drops any held result. A request presented with `flush` high is not accepted.
- Reset: state IDLE, `out_valid=0`, `y=0`, `illegal=0`, counter 0. `in_ready=1` once reset deasserts. Reset mid-BUSY discards the op.

## Timing
- Latency is measured from the accepting edge to the first cycle `out_valid` is high:
  - Simple ops and divide special cases: 1 cycle.
  - MUL/DIV: XLEN+1 cycles.
- Throughput: simple ops 1/cycle back-to-back while `out_ready=1`. MUL/DIV: one per XLEN+1 cycles.
- `out_valid` holds until `out_ready` is sampled high. `y` does not change while `out_valid && !out_ready`.
- Simultaneous `flush` and `out_ready`: flush wins, no new accept.

## Configuration
- `ALU_MDU_DIV_EN`:
  - Defined: divider datapath is present, `illegal` is always 0.
  - Undefined: no divider logic. Ops 20–23 complete with latency 1, `y=0`, `illegal=1`. Multiply is unaffected.

## Test plan
- ADD a=5, b=7 → `y=12`, `out_valid` one cycle after accept. Then back-to-back SRA a=0x80000000, b=4 with `out_ready=1` → next cycle `y=0xF8000000`, no bubble.
- MUL/MULHU a=b=0xFFFFFFFF → `y=0x00000001` / `0xFFFFFFFE`, latency 33, `in_ready=0` throughout BUSY. MULH a=−3, b=7 → `y=0xFFFFFFFF`.
- DIV a=−7, b=2 → quotient `0xFFFFFFFD`; REM → `0xFFFFFFFF`. Special cases:
  - DIVU a=9, b=0 → `0xFFFFFFFF`; REMU → 9, latency 1.
  - DIV a=0x80000000, b=−1 → `0x80000000`; REM → 0.
- Backpressure: hold `out_ready=0` for 10 cycles after a DIV completes → `y` stable, `in_ready=0`. Raise `out_ready` together with a new ADD request → accepted on that edge.
- `flush` at BUSY cycle 12 of a MUL → IDLE next cycle, `out_valid` never asserts. Repeat using `rst` mid-BUSY → outputs return to reset values immediately (asynchronous).
- Build without `ALU_MDU_DIV_EN`: DIV 10/2 → `y=0`, `illegal=1`, latency 1. MUL 6×7 → 42, `illegal=0`.
